// File: rtl/serial_adder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle adder/subtractor. Operands are latched on an accepted start
// and the result is resolved LSB-first, BITS_PER_CYCLE bits per clock,
// through a small full-adder chain fed by a registered carry. After
// N = WIDTH / BITS_PER_CYCLE compute edges the sum, carry-out and signed
// overflow are published together with a one-cycle done pulse.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous, active-high reset
//   start_i  operation request, accepted only while idle
//   sub_i    0: a + b + c_in, 1: a - b (c_in ignored)
//   a_i      operand A
//   b_i      operand B
//   c_in_i   carry-in for addition
//   busy_o   operation in progress
//   done_o   one-cycle pulse, results valid
//   sum_o    result modulo 2^WIDTH
//   c_out_o  carry out of the MSB (1 = no borrow for subtraction)
//   ovf_o    signed overflow
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH          = 4,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out_o,
  output logic             ovf_o
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  // Refuse to build a configuration whose width is not a whole number of
  // compute steps.
  if (WIDTH < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : gInvalidConfig
    $error("serial_adder: WIDTH must be >= 1 and a multiple of BITS_PER_CYCLE");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [WIDTH-1:0]            aSh_q, aSh_d;
  logic [WIDTH-1:0]            bSh_q, bSh_d;
  logic                        carry_q, carry_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [WIDTH-1:0]            res_q, res_d;
  logic [WIDTH-1:0]            sum_q, sum_d;
  logic                        cOut_q, cOut_d;
  logic                        ovf_q, ovf_d;
  logic                        done_q, done_d;

  logic [BITS_PER_CYCLE:0]     chainC;
  logic [BITS_PER_CYCLE-1:0]   stepSum;
  logic [WIDTH-1:0]            stepWide;
  logic [WIDTH-1:0]            resNext;

  // Full-adder chain over the low slice of the operand shift registers.
  // chainC[BITS_PER_CYCLE-1] is the carry into the top bit of the slice,
  // which on the final step is the carry into the MSB of the word.
  // The new slice enters the result register from the MSB side so that
  // after N steps the first slice computed sits at the bottom.
  always_comb begin
    chainC    = '0;
    stepSum   = '0;
    chainC[0] = carry_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      stepSum[i]  = aSh_q[i] ^ bSh_q[i] ^ chainC[i];
      chainC[i+1] = (aSh_q[i] & bSh_q[i]) | (chainC[i] & (aSh_q[i] ^ bSh_q[i]));
    end
    stepWide                   = '0;
    stepWide[BITS_PER_CYCLE-1:0] = stepSum;
    resNext = (res_q >> BITS_PER_CYCLE) | (stepWide << (WIDTH - BITS_PER_CYCLE));
  end

  // Next-state logic. Output registers only change on the last compute
  // step, so a partial result is never visible on sum_o.
  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cOut_d  = cOut_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          // Subtraction is a + ~b + 1: invert B and force the carry in.
          aSh_d   = a_i;
          bSh_d   = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? 1'b1 : c_in_i;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        aSh_d   = aSh_q >> BITS_PER_CYCLE;
        bSh_d   = bSh_q >> BITS_PER_CYCLE;
        carry_d = chainC[BITS_PER_CYCLE];
        cnt_d   = cnt_q + CNT_W'(1);
        res_d   = resNext;
        if (cnt_q == LAST_STEP) begin
          sum_d   = resNext;
          cOut_d  = chainC[BITS_PER_CYCLE];
          ovf_d   = chainC[BITS_PER_CYCLE] ^ chainC[BITS_PER_CYCLE-1];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any running operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cOut_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cOut_q  <= cOut_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;
  assign sum_o   = sum_q;
  assign c_out_o = cOut_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Bench for serial_adder in two configurations: WIDTH=4/BITS_PER_CYCLE=1
// and WIDTH=8/BITS_PER_CYCLE=2. Expected results are queued when an
// operation is launched and popped when done is observed.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start4, start8;
  logic       sub, cin;
  logic [7:0] a, b;

  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  exp_t       sb[$];
  int         nCompared   = 0;
  int         nMismatched = 0;

  serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(1)) dut4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start4),
    .sub_i   (sub),
    .a_i     (a[3:0]),
    .b_i     (b[3:0]),
    .c_in_i  (cin),
    .busy_o  (busy4),
    .done_o  (done4),
    .sum_o   (sum4),
    .c_out_o (cout4),
    .ovf_o   (ovf4)
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut8 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start8),
    .sub_i   (sub),
    .a_i     (a),
    .b_i     (b),
    .c_in_i  (cin),
    .busy_o  (busy8),
    .done_o  (done8),
    .sum_o   (sum8),
    .c_out_o (cout8),
    .ovf_o   (ovf8)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never completes
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: integer arithmetic for the sum, sign rule for overflow
  function automatic exp_t model(int w, int av, int bv, bit s, bit ci);
    int   mask;
    int   bb;
    int   c;
    int   full;
    exp_t e;
    mask   = (1 << w) - 1;
    bb     = s ? (~bv & mask) : (bv & mask);
    c      = s ? 1 : int'(ci);
    full   = (av & mask) + bb + c;
    e.sum  = 8'(full & mask);
    e.cout = full[w];
    e.ovf  = (av[w-1] == bb[w-1]) && (full[w-1] != av[w-1]);
    return e;
  endfunction

  function automatic logic getDone(int sel);
    return (sel == 8) ? done8 : done4;
  endfunction

  function automatic logic getBusy(int sel);
    return (sel == 8) ? busy8 : busy4;
  endfunction

  function automatic logic [7:0] getSum(int sel);
    return (sel == 8) ? sum8 : {4'h0, sum4};
  endfunction

  function automatic logic getCout(int sel);
    return (sel == 8) ? cout8 : cout4;
  endfunction

  function automatic logic getOvf(int sel);
    return (sel == 8) ? ovf8 : ovf4;
  endfunction

  // Drive an operation at a negedge, queue its expected result, and release
  // start just after the accepting edge.
  task automatic applyStimulus(int sel, logic [7:0] av, logic [7:0] bv,
                               logic s, logic ci, exp_t e);
    a   = av;
    b   = bv;
    sub = s;
    cin = ci;
    if (sel == 8) start8 = 1'b1; else start4 = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Count edges after accept until done shows; bounded.
  task automatic waitDone(int sel, output int lat, output logic busyAt);
    lat = 0;
    @(negedge clk);
    busyAt = getBusy(sel);
    while (!getDone(sel) && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start4 = 1'b1;
    start8 = 1'b1;
    a      = 8'hFF;
    b      = 8'h01;
    sub    = 1'b0;
    cin    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nCompared++; if (busy4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy4: got %b expected 0", busy4); end
    nCompared++; if (done4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done4: got %b expected 0", done4); end
    nCompared++; if (sum4 !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_sum4: got %h expected 0", sum4); end
    nCompared++; if (cout4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_cout4: got %b expected 0", cout4); end
    nCompared++; if (ovf4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ovf4: got %b expected 0", ovf4); end
    nCompared++; if (busy8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy8: got %b expected 0", busy8); end
    nCompared++; if (done8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done8: got %b expected 0", done8); end
    nCompared++; if (sum8 !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_sum8: got %h expected 0", sum8); end
    nCompared++; if (cout8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_cout8: got %b expected 0", cout8); end
    nCompared++; if (ovf8 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ovf8: got %b expected 0", ovf8); end
    rst    = 1'b0;
    start4 = 1'b0;
    start8 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    int   lat;
    logic busyAt;
    exp_t e;
    applyStimulus(4, 8'd7, 8'd8, 1'b0, 1'b1, '{8'h00, 1'b1, 1'b0});
    waitDone(4, lat, busyAt);
    e = sb.pop_front();
    nCompared++; if (busyAt !== 1'b1) begin nMismatched++; $display("[TB] FAIL add_busy: got %b expected 1", busyAt); end
    nCompared++; if (lat != 4) begin nMismatched++; $display("[TB] FAIL add_latency: got %0d expected 4", lat); end
    nCompared++; if (sum4 !== e.sum[3:0]) begin nMismatched++; $display("[TB] FAIL add_sum: got %h expected %h", sum4, e.sum[3:0]); end
    nCompared++; if (cout4 !== e.cout) begin nMismatched++; $display("[TB] FAIL add_cout: got %b expected %b", cout4, e.cout); end
    nCompared++; if (ovf4 !== e.ovf) begin nMismatched++; $display("[TB] FAIL add_ovf: got %b expected %b", ovf4, e.ovf); end
    @(negedge clk);
    nCompared++; if (done4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_done_pulse: got %b expected 0", done4); end
    nCompared++; if (busy4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_idle: got %b expected 0", busy4); end
  endtask

  task automatic test_sub_ovf();
    int   lat;
    logic busyAt;
    exp_t e;
    applyStimulus(4, 8'd3, 8'd5, 1'b1, 1'b0, '{8'h0E, 1'b0, 1'b0});
    waitDone(4, lat, busyAt);
    e = sb.pop_front();
    nCompared++; if (lat != 4) begin nMismatched++; $display("[TB] FAIL sub_latency: got %0d expected 4", lat); end
    nCompared++; if (sum4 !== e.sum[3:0]) begin nMismatched++; $display("[TB] FAIL sub_sum: got %h expected %h", sum4, e.sum[3:0]); end
    nCompared++; if (cout4 !== e.cout) begin nMismatched++; $display("[TB] FAIL sub_cout: got %b expected %b", cout4, e.cout); end
    nCompared++; if (ovf4 !== e.ovf) begin nMismatched++; $display("[TB] FAIL sub_ovf: got %b expected %b", ovf4, e.ovf); end
    applyStimulus(4, 8'd7, 8'd1, 1'b0, 1'b0, '{8'h08, 1'b0, 1'b1});
    waitDone(4, lat, busyAt);
    e = sb.pop_front();
    nCompared++; if (lat != 4) begin nMismatched++; $display("[TB] FAIL ovf_latency: got %0d expected 4", lat); end
    nCompared++; if (sum4 !== e.sum[3:0]) begin nMismatched++; $display("[TB] FAIL ovf_sum: got %h expected %h", sum4, e.sum[3:0]); end
    nCompared++; if (cout4 !== e.cout) begin nMismatched++; $display("[TB] FAIL ovf_cout: got %b expected %b", cout4, e.cout); end
    nCompared++; if (ovf4 !== e.ovf) begin nMismatched++; $display("[TB] FAIL ovf_ovf: got %b expected %b", ovf4, e.ovf); end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic busyAt;
    exp_t e;
    applyStimulus(4, 8'd1, 8'd2, 1'b0, 1'b0, '{8'h03, 1'b0, 1'b0});
    waitDone(4, lat, busyAt);
    e = sb.pop_front();
    nCompared++; if (sum4 !== e.sum[3:0]) begin nMismatched++; $display("[TB] FAIL b2b_first_sum: got %h expected %h", sum4, e.sum[3:0]); end
    // Still in the done cycle: the next request goes in now
    applyStimulus(4, 8'd15, 8'd15, 1'b0, 1'b1, '{8'h0F, 1'b1, 1'b0});
    waitDone(4, lat, busyAt);
    e = sb.pop_front();
    nCompared++; if (busyAt !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_accept: got %b expected 1", busyAt); end
    nCompared++; if (lat != 4) begin nMismatched++; $display("[TB] FAIL b2b_latency: got %0d expected 4", lat); end
    nCompared++; if (sum4 !== e.sum[3:0]) begin nMismatched++; $display("[TB] FAIL b2b_sum: got %h expected %h", sum4, e.sum[3:0]); end
    nCompared++; if (cout4 !== e.cout) begin nMismatched++; $display("[TB] FAIL b2b_cout: got %b expected %b", cout4, e.cout); end
    nCompared++; if (ovf4 !== e.ovf) begin nMismatched++; $display("[TB] FAIL b2b_ovf: got %b expected %b", ovf4, e.ovf); end
  endtask

  task automatic test_ignore_start();
    int   lat;
    int   extraDone;
    exp_t e;
    applyStimulus(4, 8'd2, 8'd3, 1'b0, 1'b0, '{8'h05, 1'b0, 1'b0});
    lat = 0;
    @(negedge clk);
    while (!done4 && lat < 30) begin
      nCompared++; if (sum4 !== 4'hF) begin nMismatched++; $display("[TB] FAIL hold_sum: got %h expected f", sum4); end
      if (lat == 1) begin
        start4 = 1'b1;
        a      = 8'd9;
        b      = 8'd9;
        sub    = 1'b1;
      end else begin
        start4 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start4 = 1'b0;
    e = sb.pop_front();
    nCompared++; if (lat != 4) begin nMismatched++; $display("[TB] FAIL ignore_latency: got %0d expected 4", lat); end
    nCompared++; if (sum4 !== e.sum[3:0]) begin nMismatched++; $display("[TB] FAIL ignore_sum: got %h expected %h", sum4, e.sum[3:0]); end
    nCompared++; if (cout4 !== e.cout) begin nMismatched++; $display("[TB] FAIL ignore_cout: got %b expected %b", cout4, e.cout); end
    extraDone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4) extraDone++;
    end
    nCompared++; if (extraDone != 0) begin nMismatched++; $display("[TB] FAIL ignore_no_extra_done: got %0d expected 0", extraDone); end
  endtask

  task automatic test_reset_midop();
    int   lat;
    int   extraDone;
    logic busyAt;
    exp_t e;
    a      = 8'd5;
    b      = 8'd6;
    sub    = 1'b0;
    cin    = 1'b0;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nCompared++; if (busy4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", busy4); end
    nCompared++; if (done4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_done: got %b expected 0", done4); end
    nCompared++; if (sum4 !== 4'h0) begin nMismatched++; $display("[TB] FAIL abort_sum: got %h expected 0", sum4); end
    nCompared++; if (cout4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_cout: got %b expected 0", cout4); end
    nCompared++; if (ovf4 !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_ovf: got %b expected 0", ovf4); end
    extraDone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4) extraDone++;
    end
    nCompared++; if (extraDone != 0) begin nMismatched++; $display("[TB] FAIL abort_no_done: got %0d expected 0", extraDone); end
    applyStimulus(4, 8'd4, 8'd4, 1'b0, 1'b0, '{8'h08, 1'b0, 1'b1});
    waitDone(4, lat, busyAt);
    e = sb.pop_front();
    nCompared++; if (lat != 4) begin nMismatched++; $display("[TB] FAIL after_abort_latency: got %0d expected 4", lat); end
    nCompared++; if (sum4 !== e.sum[3:0]) begin nMismatched++; $display("[TB] FAIL after_abort_sum: got %h expected %h", sum4, e.sum[3:0]); end
    nCompared++; if (ovf4 !== e.ovf) begin nMismatched++; $display("[TB] FAIL after_abort_ovf: got %b expected %b", ovf4, e.ovf); end
  endtask

  task automatic test_wide();
    int   lat;
    logic busyAt;
    exp_t e;
    applyStimulus(8, 8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0});
    waitDone(8, lat, busyAt);
    e = sb.pop_front();
    nCompared++; if (lat != 4) begin nMismatched++; $display("[TB] FAIL wide_latency: got %0d expected 4", lat); end
    nCompared++; if (sum8 !== e.sum) begin nMismatched++; $display("[TB] FAIL wide_sum: got %h expected %h", sum8, e.sum); end
    nCompared++; if (cout8 !== e.cout) begin nMismatched++; $display("[TB] FAIL wide_cout: got %b expected %b", cout8, e.cout); end
    nCompared++; if (ovf8 !== e.ovf) begin nMismatched++; $display("[TB] FAIL wide_ovf: got %b expected %b", ovf8, e.ovf); end
  endtask

  // Random-operation sweep against the model; exhaustive operand pairs for
  // the 4-bit instance, random operands for the 8-bit one.
  task automatic test_sweep(int sel, int count);
    int   lat;
    int   av;
    int   bv;
    bit   s;
    bit   ci;
    logic busyAt;
    exp_t e;
    exp_t got;
    for (int n = 0; n < count; n++) begin
      if (sel == 8) begin
        av = int'($urandom_range(0, 255));
        bv = int'($urandom_range(0, 255));
      end else begin
        av = n % 16;
        bv = n / 16;
      end
      s  = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      applyStimulus(sel, 8'(av), 8'(bv), s, ci, model((sel == 8) ? 8 : 4, av, bv, s, ci));
      waitDone(sel, lat, busyAt);
      e = sb.pop_front();
      got = '{getSum(sel), getCout(sel), getOvf(sel)};
      nCompared++; if (lat != 4) begin nMismatched++; $display("[TB] FAIL sweep%0d_latency: got %0d expected 4", sel, lat); end
      nCompared++; if (got !== e) begin
        nMismatched++;
        $display("[TB] FAIL sweep%0d_result a=%h b=%h sub=%b cin=%b: got sum=%h c=%b v=%b expected sum=%h c=%b v=%b",
                 sel, av, bv, s, ci, got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    start4 = 1'b0;
    start8 = 1'b0;
    sub    = 1'b0;
    cin    = 1'b0;
    a      = '0;
    b      = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub_ovf();
    test_back_to_back();
    test_ignore_start();
    test_reset_midop();
    test_wide();
    test_sweep(4, 256);
    test_sweep(8, 120);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
